// File: rtl/pulse_train_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_train_gen_pkg
// Shared definitions for the pulse train generator: FSM state encoding,
// default field widths and the electrical sense of the output pin.
// ---------------------------------------------------------------------------
package pulse_train_gen_pkg;

   localparam int unsigned DEFAULT_LEN_WIDTH = 16;
   localparam int unsigned DEFAULT_NUM_WIDTH = 16;

   // The pin is active-low, so it idles high to match the inverted sense on the input side.
   localparam logic PIN_ASSERTED = 1'b0;
   localparam logic PIN_RELEASED = ~PIN_ASSERTED;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_GAP    = 2'd2
   } state_e;

endpackage : pulse_train_gen_pkg

// File: rtl/pulse_train_gen_phase_down_counter.sv
// ---------------------------------------------------------------------------
// phase_down_counter
// Loadable down-counter that times one phase (asserted or released) of a
// pulse. It is loaded with (length - 1) and counts down to zero. It holds at
// zero and never wraps. tc_o is high while the count is zero, which marks
// the last cycle of the phase.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-low reset (count -> 0)
//   load_i      load load_val_i (has priority over en_i)
//   load_val_i  value to load, phase length minus one
//   en_i        decrement enable
//   tc_o        terminal count, high when count == 0
// ---------------------------------------------------------------------------
module phase_down_counter
   import pulse_train_gen_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_LEN_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == '0);

endmodule : phase_down_counter

// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
// Drives an active-low pin with a train of N clean pulses. Each pulse holds
// the pin low for H cycles and then high for L cycles, with
// H = max(high_len_i,1) and L = max(low_len_i,1). Every train ends with a
// full release gap, so back-to-back trains always keep a release time between
// them. All outputs are registered.
//
// Ports:
//   clk_i       clock, all logic on posedge
//   rst_i       asynchronous active-low reset
//   start_i     start request, sampled only in IDLE
//   abort_i     synchronous abort, highest priority after reset
//   high_len_i  asserted (pin low) length, latched at start
//   low_len_i   released (pin high) length, latched at start
//   num_i       number of pulses, latched at start (0 -> immediate done)
//   pin_o       active-low pulse output, 1 = released/idle
//   pulse_o     1-cycle strobe in the first asserted cycle of each pulse
//   busy_o      high while a train is in progress
//   done_o      1-cycle strobe after a train completes normally
// ---------------------------------------------------------------------------
module pulse_train_gen
   import pulse_train_gen_pkg::*;
#(
   parameter int unsigned LEN_WIDTH = DEFAULT_LEN_WIDTH,
   parameter int unsigned NUM_WIDTH = DEFAULT_NUM_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [LEN_WIDTH-1:0] high_len_i,
   input  logic [LEN_WIDTH-1:0] low_len_i,
   input  logic [NUM_WIDTH-1:0] num_i,
   output logic                 pin_o,
   output logic                 pulse_o,
   output logic                 busy_o,
   output logic                 done_o
);

   state_e               state_q,  state_d;
   logic                 pin_q,    pin_d;
   logic                 pulse_q,  pulse_d;
   logic                 busy_q,   busy_d;
   logic                 done_q,   done_d;
   // Phase lengths are stored as (length - 1), the counter reload value.
   logic [LEN_WIDTH-1:0] high_m1_q, high_m1_d;
   logic [LEN_WIDTH-1:0] low_m1_q,  low_m1_d;
   // Pulses still to be emitted, including the one in progress.
   logic [NUM_WIDTH-1:0] remain_q,  remain_d;

   logic                 cnt_load;
   logic [LEN_WIDTH-1:0] cnt_load_val;
   logic                 cnt_en;
   logic                 cnt_tc;

   // A zero length behaves as one cycle, so its reload value is 0 as well.
   logic [LEN_WIDTH-1:0] high_in_m1;
   logic [LEN_WIDTH-1:0] low_in_m1;
   assign high_in_m1 = (high_len_i == '0) ? '0 : high_len_i - LEN_WIDTH'(1);
   assign low_in_m1  = (low_len_i  == '0) ? '0 : low_len_i  - LEN_WIDTH'(1);

   phase_down_counter #(
      .WIDTH (LEN_WIDTH)
   ) u_phase_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .en_i       (cnt_en),
      .tc_o       (cnt_tc)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      pin_d        = pin_q;
      pulse_d      = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      high_m1_d    = high_m1_q;
      low_m1_d     = low_m1_q;
      remain_d     = remain_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;

      if (abort_i) begin
         state_d = ST_IDLE;
         pin_d   = PIN_RELEASED;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  if (num_i != '0) begin
                     high_m1_d    = high_in_m1;
                     low_m1_d     = low_in_m1;
                     remain_d     = num_i;
                     state_d      = ST_ASSERT;
                     pin_d        = PIN_ASSERTED;
                     pulse_d      = 1'b1;
                     busy_d       = 1'b1;
                     cnt_load     = 1'b1;
                     cnt_load_val = high_in_m1;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end

            ST_ASSERT: begin
               if (cnt_tc) begin
                  state_d      = ST_GAP;
                  pin_d        = PIN_RELEASED;
                  cnt_load     = 1'b1;
                  cnt_load_val = low_m1_q;
               end else begin
                  cnt_en = 1'b1;
               end
            end

            ST_GAP: begin
               if (cnt_tc) begin
                  // Comparing against 1 before decrementing keeps an all-ones
                  // count free of any overflow.
                  remain_d = remain_q - NUM_WIDTH'(1);
                  if (remain_q == NUM_WIDTH'(1)) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d      = ST_ASSERT;
                     pin_d        = PIN_ASSERTED;
                     pulse_d      = 1'b1;
                     cnt_load     = 1'b1;
                     cnt_load_val = high_m1_q;
                  end
               end else begin
                  cnt_en = 1'b1;
               end
            end

            default: begin
               state_d = ST_IDLE;
               pin_d   = PIN_RELEASED;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= ST_IDLE;
         pin_q     <= PIN_RELEASED;
         pulse_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         high_m1_q <= '0;
         low_m1_q  <= '0;
         remain_q  <= '0;
      end else begin
         state_q   <= state_d;
         pin_q     <= pin_d;
         pulse_q   <= pulse_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         high_m1_q <= high_m1_d;
         low_m1_q  <= low_m1_d;
         remain_q  <= remain_d;
      end
   end

   assign pin_o   = pin_q;
   assign pulse_o = pulse_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
// Self-checking bench for pulse_train_gen. A timeline model describes each
// accepted train by its start cycle, H, L and N. Expected outputs for any
// cycle come from arithmetic on the offset into that train. A compare
// process checks all four outputs on every falling clock edge. Directed
// sequences pin literal waveforms, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;

   localparam int LW = 16;
   localparam int NW = 16;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [LW-1:0] high_len_i = '0;
   logic [LW-1:0] low_len_i = '0;
   logic [NW-1:0] num_i = '0;
   logic          pin_o, pulse_o, busy_o, done_o;

   pulse_train_gen #(.LEN_WIDTH(LW), .NUM_WIDTH(NW)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .high_len_i (high_len_i),
      .low_len_i  (low_len_i),
      .num_i      (num_i),
      .pin_o      (pin_o),
      .pulse_o    (pulse_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk_i = ~clk_i;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- timeline model ----------------
   int cyc     = 0;
   bit active  = 1'b0;
   int t0      = 0;
   int m_h     = 1;
   int m_l     = 1;
   int m_n     = 0;
   int done_at = -1;

   function automatic bit m_busy(input int c);
      return active && (c >= t0) && (c < t0 + m_n * (m_h + m_l));
   endfunction

   function automatic bit m_pin(input int c);
      if (!m_busy(c)) return 1'b1;
      return ((c - t0) % (m_h + m_l)) >= m_h;
   endfunction

   function automatic bit m_pulse(input int c);
      return m_busy(c) && (((c - t0) % (m_h + m_l)) == 0);
   endfunction

   function automatic bit m_done(input int c);
      return c == done_at;
   endfunction

   always @(posedge clk_i or negedge rst_i) begin
      bit was_busy;
      if (!rst_i) begin
         cyc     = cyc + 1;
         active  = 1'b0;
         done_at = -1;
      end else begin
         was_busy = m_busy(cyc);
         cyc = cyc + 1;
         if (abort_i) begin
            active = 1'b0;
            if (done_at >= cyc) done_at = -1;
         end else if (start_i && !was_busy) begin
            if (num_i == '0) begin
               done_at = cyc;
            end else begin
               m_h     = (high_len_i == '0) ? 1 : int'(high_len_i);
               m_l     = (low_len_i  == '0) ? 1 : int'(low_len_i);
               m_n     = int'(num_i);
               t0      = cyc;
               active  = 1'b1;
               done_at = cyc + m_n * (m_h + m_l);
            end
         end
      end
   end

   always @(negedge clk_i) begin
      check("cmp_pin",   pin_o,   m_pin(cyc));
      check("cmp_pulse", pulse_o, m_pulse(cyc));
      check("cmp_busy",  busy_o,  m_busy(cyc));
      check("cmp_done",  done_o,  m_done(cyc));
   end

   // ---------------- stimulus helpers ----------------
   // Returns at the falling edge of the first cycle after the start edge.
   task automatic start_train(input int h, input int l, input int n);
      @(negedge clk_i);
      high_len_i = LW'(h);
      low_len_i  = LW'(l);
      num_i      = NW'(n);
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i    = 1'b0;
   endtask

   task automatic record(input int n, output logic [63:0] pins, output logic [63:0] pulses,
                         output int busy_cnt, output int done_idx);
      pins = '1; pulses = '0; busy_cnt = 0; done_idx = -1;
      for (int i = 0; i < n; i++) begin
         pins[i]   = pin_o;
         pulses[i] = pulse_o;
         busy_cnt += int'(busy_o);
         if (done_o && done_idx < 0) done_idx = i;
         @(negedge clk_i);
      end
   endtask

   task automatic wait_done(input int budget, input string name);
      int k = 0;
      while (!done_o && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      check(name, done_o, 1'b1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [63:0] pins, pulses;
      int bc, di, dcnt, pcnt;

      // Reset held for three cycles, then twenty idle cycles.
      repeat (3) @(negedge clk_i);
      check("rst_pin",  pin_o,  1'b1);
      check("rst_busy", busy_o, 1'b0);
      rst_i = 1'b1;
      repeat (20) @(negedge clk_i);
      check("idle_pin", pin_o, 1'b1);

      // Basic train H=3 L=2 N=4.
      start_train(3, 2, 4);
      record(25, pins, pulses, bc, di);
      check("basic_pins",   pins[24:0],  25'b11111_11000_11000_11000_11000);
      check("basic_pulses", pulses[24:0], 25'b00000_00001_00001_00001_00001);
      check("basic_busy",   bc, 20);
      check("basic_done",   di, 20);

      // N=0: immediate done, no pulse.
      start_train(5, 5, 0);
      check("n0_done", done_o, 1'b1);
      check("n0_busy", busy_o, 1'b0);
      check("n0_pin",  pin_o,  1'b1);
      @(negedge clk_i);
      check("n0_done_once", done_o, 1'b0);

      // H=0 L=0 N=3 behaves as H=L=1.
      start_train(0, 0, 3);
      record(8, pins, pulses, bc, di);
      check("zero_pins", pins[7:0], 8'b11101010);
      check("zero_busy", bc, 6);
      check("zero_done", di, 6);

      // Abort during cycle 4 of the first pulse, then a clean short train.
      start_train(10, 10, 5);
      repeat (3) @(negedge clk_i);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      check("abort_pin",  pin_o,  1'b1);
      check("abort_busy", busy_o, 1'b0);
      dcnt = 0;
      for (int i = 0; i < 25; i++) begin
         dcnt += int'(done_o);
         @(negedge clk_i);
      end
      check("abort_no_done", dcnt, 0);
      start_train(2, 1, 1);
      record(5, pins, pulses, bc, di);
      check("post_abort_pins", pins[4:0], 5'b11100);
      check("post_abort_done", di, 3);

      // Abort together with start in IDLE: abort wins.
      @(negedge clk_i);
      num_i = NW'(2); start_i = 1'b1; abort_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; abort_i = 1'b0;
      check("abort_start_busy", busy_o, 1'b0);

      // Start pulses and field changes mid-train are ignored.
      start_train(4, 3, 3);
      bc = 0; di = -1; pcnt = 0;
      for (int i = 0; i < 28; i++) begin
         bc   += int'(busy_o);
         pcnt += int'(pulse_o);
         if (done_o && di < 0) di = i;
         if (i == 2) begin
            start_i = 1'b1; high_len_i = LW'(9); low_len_i = LW'(9); num_i = NW'(9);
         end
         if (i == 3) start_i = 1'b0;
         if (i == 10) begin
            high_len_i = LW'(1); low_len_i = LW'(7); num_i = NW'(1);
         end
         @(negedge clk_i);
      end
      check("ign_busy",   bc, 21);
      check("ign_pulses", pcnt, 3);
      check("ign_done",   di, 21);

      // Start accepted in the done cycle.
      start_train(2, 2, 1);
      wait_done(20, "b2b_first_done");
      high_len_i = LW'(1); low_len_i = LW'(1); num_i = NW'(2); start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check("b2b_pin",   pin_o,   1'b0);
      check("b2b_pulse", pulse_o, 1'b1);
      check("b2b_busy",  busy_o,  1'b1);
      wait_done(20, "b2b_second_done");

      // Asynchronous reset during GAP.
      start_train(3, 5, 2);
      repeat (4) @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      check("arst_pin",  pin_o,  1'b1);
      check("arst_busy", busy_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         dcnt += int'(done_o);
         @(negedge clk_i);
      end
      check("arst_no_done", dcnt, 0);

      // Randomized traffic, checked by the compare process.
      for (int i = 0; i < 2500; i++) begin
         start_i    = ($urandom_range(0, 9) == 0);
         abort_i    = ($urandom_range(0, 79) == 0);
         high_len_i = LW'($urandom_range(0, 5));
         low_len_i  = LW'($urandom_range(0, 5));
         num_i      = NW'($urandom_range(0, 4));
         @(negedge clk_i);
      end
      start_i = 1'b0; abort_i = 1'b0;
      repeat (150) @(negedge clk_i);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_pulse_train_gen

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Transmit-side counterpart to the input debouncer. Drives an active-low output pin with a programmable train of clean pulses: N pulses, each with a fixed asserted time and release time. Used to stimulate the multichannel counter inputs, either looped back on the board or wired to external pins. All outputs are registered, and the pin is idle-high, so its polarity matches the inverted pin sense on the input side.

Parameters:
LEN_WIDTH, 16, width of the asserted-length and released-length fields, in clk_i cycles.
NUM_WIDTH, 16, width of the pulse-count field.

Ports:
clk_i  input  1  clock; all logic on posedge.
rst_i  input  1  reset, asynchronous, active-low.
start_i  input  1  start request; sampled only in IDLE.
abort_i  input  1  synchronous abort; has priority over everything except reset.
high_len_i  input  LEN_WIDTH  asserted (pin low) cycles per pulse; latched at start.
low_len_i  input  LEN_WIDTH  released (pin high) cycles after each pulse; latched at start.
num_i  input  NUM_WIDTH  number of pulses; latched at start.
pin_o  output  1  active-low pulse output; 1 = released/idle.
pulse_o  output  1  1-cycle strobe in the first cycle of each asserted phase.
busy_o  output  1  high while a train is in progress.
done_o  output  1  1-cycle strobe when a train completes normally.

Behaviour:
- Reset values: pin_o=1, pulse_o=0, busy_o=0, done_o=0, state=IDLE, all counters 0. Reset mid-train releases the pin immediately (asynchronous).
- Length fields: define H = max(high_len_i,1) and L = max(low_len_i,1). A length of 0 is treated as 1.
- States: IDLE, ASSERT, GAP.
- IDLE, start_i=1, num_i!=0 (sampled at edge k):
  - Latch H, L, num_i.
  - At edge k: state<=ASSERT, pin_o<=0, pulse_o<=1, busy_o<=1.
- IDLE, start_i=1, num_i=0: no pulses; done_o<=1 for one cycle at edge k; busy_o stays 0.
- ASSERT: pin_o is low for exactly H cycles; pulse_o is high only in the first of them. Then state<=GAP, pin_o<=1.
- GAP: pin_o is high for exactly L cycles. At the end, decrement the remaining count.
  - Remaining > 0: go to ASSERT (pin_o<=0, pulse_o<=1).
  - Remaining = 0: go to IDLE with busy_o<=0 and done_o<=1 for one cycle.
  - The last pulse is always followed by a full GAP, which guarantees release time between back-to-back trains.
- Timing:
  - busy_o is high for exactly N*(H+L) cycles.
  - done_o asserts in the cycle after busy_o falls.
  - start_i in that same cycle is accepted, because the state is IDLE.
- start_i while busy is ignored; latched parameters are unaffected by input changes mid-train.
- abort_i=1 in any state (edge k): state<=IDLE, pin_o<=1, busy_o<=0, pulse_o<=0, no done_o. abort_i together with start_i in IDLE gives abort priority, so no start occurs.
- Counters:
  - Phase counter is LEN_WIDTH bits and counts down from H-1 (or L-1) to 0, with no wrap.
  - Pulse counter is NUM_WIDTH bits. Maximum values (all ones) must work without overflow.

Decomposition:
- Shared package pulse_train_gen_pkg holds:
  - the state enum (IDLE, ASSERT, GAP);
  - the default widths;
  - the localparam PIN_ASSERTED = 1'b0.
- One natural sub-module, phase_down_counter:
  - a LEN_WIDTH loadable down-counter with load, enable and terminal-count outputs;
  - used for both ASSERT and GAP phases.

Test Plan:
- Reset then idle: rst_i low for 3 cycles -> pin_o=1, busy_o=0, done_o=0, pulse_o=0 throughout; no activity for 20 cycles with start_i=0.
- Basic train: H=3, L=2, N=4 -> pin_o pattern 000 11 repeated 4 times; busy_o high for 20 cycles; 4 pulse_o strobes spaced 5 cycles apart; single done_o in cycle 21.
- Zero cases: N=0 -> done_o one cycle after start, pin_o stays 1, busy_o stays 0. H=0, L=0, N=3 -> pattern 0 1 repeated 3 times (treated as 1), busy_o for 6 cycles.
- Abort mid-ASSERT: H=10, L=10, N=5, abort_i in cycle 4 of the first pulse -> pin_o=1 next cycle, busy_o=0, no done_o. A new start with H=2, L=1, N=1 then runs cleanly.
- Back-to-back and ignored start: start_i pulsed during the train is ignored, and changing input fields mid-train has no effect. start_i in the done_o cycle starts a new train, with pin_o low on the next cycle.
- Asynchronous reset mid-GAP: assert rst_i between clock edges -> pin_o=1 and busy_o=0 immediately. After release, the FSM is in IDLE and no done_o is issued.
